// File: rtl/regs_writeback.sv
// Lane-serialising register writeback: a small input FIFO feeds a two-state writer
// that commits one lane per cycle into a 64-entry register file exported as flat buses.
module regs_writeback #(
  parameter int DATA_WIDTH          = 4,
  parameter int LANES               = 4,
  parameter int REGS_INPUTS         = 64,
  parameter int REGS_BITS_PER_INPUT = 32,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  input  logic [DATA_WIDTH*LANES-1:0]           data_in,
  input  logic [LANES*$clog2(REGS_INPUTS)-1:0]  dest,
  input  logic [LANES-1:0]                      lane_en,
  output logic                                  wBusy,
  output logic [REGS_BITS_PER_INPUT-1:0]        wRegs0,
  output logic [REGS_BITS_PER_INPUT-1:0]        wRegs1,
  output logic [REGS_BITS_PER_INPUT-1:0]        wRegs2,
  output logic [REGS_BITS_PER_INPUT-1:0]        wRegs3,
  output logic [REGS_BITS_PER_INPUT-1:0]        wRegs4,
  output logic [REGS_BITS_PER_INPUT-1:0]        wRegs5,
  output logic [REGS_BITS_PER_INPUT-1:0]        wRegs6,
  output logic [REGS_BITS_PER_INPUT-1:0]        wRegs7,
  output logic                                  wr_done,
  output logic                                  overflow
);

  localparam int DW = $clog2(REGS_INPUTS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int RB = REGS_BITS_PER_INPUT;

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [LANES-1:0]              r_mem_en   [FIFO_DEPTH];
  logic [LANES*DW-1:0]           r_mem_dest [FIFO_DEPTH];
  logic [DATA_WIDTH*LANES-1:0]   r_mem_data [FIFO_DEPTH];
  logic [PW-1:0]                 r_wptr;
  logic [PW-1:0]                 r_rptr;
  logic [CW-1:0]                 r_count;
  logic [CW-1:0]                 w_count_nxt;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_ovf;
  logic [LANES-1:0]              r_pend;
  logic [LANES-1:0]              w_pend_nxt;
  logic [LANES*DW-1:0]           r_wdest;
  logic [DATA_WIDTH*LANES-1:0]   r_wdata;
  logic [REGS_INPUTS*DATA_WIDTH-1:0] r_regs;
  logic                          w_full;
  logic                          w_push;
  logic                          w_drop;
  logic                          w_pop;
  logic                          w_wr_en;
  logic                          w_last;
  logic [LW-1:0]                 w_lane;
  logic [DW-1:0]                 w_wr_idx;
  logic [DATA_WIDTH-1:0]         w_wr_val;

  // Fullness uses the pre-edge count, so a simultaneous pop never rescues a push.
  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_push = in_valid & ~w_full;
  assign w_drop = in_valid & w_full;
  assign w_pop  = (r_state == IDLE) && (r_count != CW'(0));

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Lowest pending lane goes first, so a later lane to the same register wins.
  always_comb begin
    w_lane = LW'(0);
    for (int i = LANES - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_lane = LW'(i);
      end else begin
        w_lane = w_lane;
      end
    end
    w_wr_idx   = r_wdest[w_lane*DW +: DW];
    w_wr_val   = r_wdata[w_lane*DATA_WIDTH +: DATA_WIDTH];
    w_wr_en    = (r_state == WRITE) && (r_pend != LANES'(0));
    w_pend_nxt = r_pend & ~(LANES'(1) << w_lane);
    w_last     = (w_pend_nxt == LANES'(0));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_pop) begin
          w_state_nxt = WRITE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WRITE: begin
        if (w_last) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WRITE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= PW'(0);
      r_rptr  <= PW'(0);
      r_count <= CW'(0);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_en[i]   <= LANES'(0);
        r_mem_dest[i] <= (LANES*DW)'(0);
        r_mem_data[i] <= (DATA_WIDTH*LANES)'(0);
      end
    end else begin
      if (w_push) begin
        r_mem_en[r_wptr]   <= lane_en;
        r_mem_dest[r_wptr] <= dest;
        r_mem_data[r_wptr] <= data_in;
        r_wptr             <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend  <= LANES'(0);
      r_wdest <= (LANES*DW)'(0);
      r_wdata <= (DATA_WIDTH*LANES)'(0);
      r_regs  <= (REGS_INPUTS*DATA_WIDTH)'(0);
    end else begin
      if (w_pop) begin
        r_pend  <= r_mem_en[r_rptr];
        r_wdest <= r_mem_dest[r_rptr];
        r_wdata <= r_mem_data[r_rptr];
      end else if (r_state == WRITE) begin
        r_pend <= w_pend_nxt;
      end
      if (w_wr_en) begin
        r_regs[w_wr_idx*DATA_WIDTH +: DATA_WIDTH] <= w_wr_val;
      end
    end
  end

  // Busy looks at the post-edge count so upstream gets one slot of slack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_busy <= (w_count_nxt >= CW'(FIFO_DEPTH - 1));
      r_done <= (r_state == WRITE) && w_last;
      r_ovf  <= r_ovf | w_drop;
    end
  end

  assign wBusy    = r_busy;
  assign wr_done  = r_done;
  assign overflow = r_ovf;
  assign wRegs0   = r_regs[0*RB +: RB];
  assign wRegs1   = r_regs[1*RB +: RB];
  assign wRegs2   = r_regs[2*RB +: RB];
  assign wRegs3   = r_regs[3*RB +: RB];
  assign wRegs4   = r_regs[4*RB +: RB];
  assign wRegs5   = r_regs[5*RB +: RB];
  assign wRegs6   = r_regs[6*RB +: RB];
  assign wRegs7   = r_regs[7*RB +: RB];

endmodule

// File: tb/tb_regs_writeback.sv
// Randomised and directed bench for regs_writeback against a queue-based
// transaction model of the FIFO, the per-lane writer and the register file.
module tb_regs_writeback;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] data_in;
  logic [23:0] dest;
  logic [3:0]  lane_en;
  logic        wBusy;
  logic [31:0] wRegs0, wRegs1, wRegs2, wRegs3, wRegs4, wRegs5, wRegs6, wRegs7;
  logic        wr_done;
  logic        overflow;
  logic [31:0] got_regs [8];

  int n_total = 0;
  int n_bad   = 0;
  int n_done_seen = 0;

  typedef struct packed {
    logic [3:0]  en;
    logic [23:0] dst;
    logic [15:0] dat;
  } ent_t;

  ent_t       m_q[$];
  int         m_lanes[$];
  ent_t       m_cur;
  bit         m_active;
  logic [3:0] m_regs [64];
  bit         m_done;
  bit         m_busy;
  bit         m_ovf;

  regs_writeback dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .dest(dest),
    .lane_en(lane_en), .wBusy(wBusy),
    .wRegs0(wRegs0), .wRegs1(wRegs1), .wRegs2(wRegs2), .wRegs3(wRegs3),
    .wRegs4(wRegs4), .wRegs5(wRegs5), .wRegs6(wRegs6), .wRegs7(wRegs7),
    .wr_done(wr_done), .overflow(overflow)
  );

  assign got_regs[0] = wRegs0;
  assign got_regs[1] = wRegs1;
  assign got_regs[2] = wRegs2;
  assign got_regs[3] = wRegs3;
  assign got_regs[4] = wRegs4;
  assign got_regs[5] = wRegs5;
  assign got_regs[6] = wRegs6;
  assign got_regs[7] = wRegs7;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_lanes.delete();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_busy   = 1'b0;
    m_ovf    = 1'b0;
    for (int i = 0; i < 64; i++) m_regs[i] = 4'h0;
  endtask

  // One clock edge of the reference: a waiting entry is taken only when no entry is in progress.
  task automatic model_step(input logic v, input logic [15:0] d, input logic [23:0] ds, input logic [3:0] e);
    bit   full;
    int   l;
    ent_t t;
    full   = (m_q.size() == 4);
    m_done = 1'b0;
    if (m_active) begin
      if (m_lanes.size() > 0) begin
        l = m_lanes.pop_front();
        m_regs[m_cur.dst[l*6 +: 6]] = m_cur.dat[l*4 +: 4];
      end
      if (m_lanes.size() == 0) begin
        m_done   = 1'b1;
        m_active = 1'b0;
      end
    end else if (m_q.size() > 0) begin
      m_cur    = m_q.pop_front();
      m_active = 1'b1;
      m_lanes.delete();
      for (int k = 0; k < 4; k++) if (m_cur.en[k]) m_lanes.push_back(k);
    end
    if (v && !full) begin
      t.en = e; t.dst = ds; t.dat = d;
      m_q.push_back(t);
    end else if (v) begin
      m_ovf = 1'b1;
    end
    m_busy = (m_q.size() >= 3);
  endtask

  task automatic compare_all();
    logic [31:0] exp;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) exp[j*4 +: 4] = m_regs[k*8 + j];
      check($sformatf("wRegs%0d", k), got_regs[k], exp);
    end
    check("wBusy", {31'd0, wBusy}, {31'd0, m_busy});
    check("wr_done", {31'd0, wr_done}, {31'd0, m_done});
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    if (wr_done) n_done_seen++;
  endtask

  task automatic drive_cycle(input logic v, input logic [15:0] d, input logic [23:0] ds, input logic [3:0] e);
    in_valid = v; data_in = d; dest = ds; lane_en = e;
    @(posedge clk);
    model_step(v, d, ds, e);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 16'h0, 24'h0, 4'h0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
  endtask

  initial begin
    int sent;
    rst = 1'b0; in_valid = 1'b0; data_in = 16'h0; dest = 24'h0; lane_en = 4'h0;
    model_reset();
    #2;
    compare_all();
    check("rst_busy", {31'd0, wBusy}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_regs0", wRegs0, 32'd0);
    @(posedge clk);
    #3 rst = 1'b1;

    // single write with four lanes, latency and pulse checks
    n_done_seen = 0;
    drive_cycle(1'b1, 16'hDCBA, {6'd63, 6'd9, 6'd8, 6'd0}, 4'hF);
    idle(1);
    check("lat_pre", {28'd0, wRegs0[3:0]}, 32'd0);
    idle(1);
    check("lat_first", {28'd0, wRegs0[3:0]}, 32'hA);
    idle(2);
    check("done_early", {31'd0, wr_done}, 32'd0);
    idle(1);
    check("done_pulse", {31'd0, wr_done}, 32'd1);
    idle(5);
    check("sw_reg0", {28'd0, wRegs0[3:0]}, 32'hA);
    check("sw_reg8_9", {24'd0, wRegs1[7:0]}, 32'hCB);
    check("sw_reg63", {28'd0, wRegs7[31:28]}, 32'hD);
    check("sw_done_cnt", n_done_seen, 32'd1);

    // back-pressure and overflow
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, 16'($urandom), 24'($urandom), 4'hF);
      if (i == 2) check("busy_low", {31'd0, wBusy}, 32'd0);
      if (i == 3) check("busy_rise", {31'd0, wBusy}, 32'd1);
      if (i == 4) check("ovf_before", {31'd0, overflow}, 32'd0);
      if (i == 5) check("ovf_set", {31'd0, overflow}, 32'd1);
    end
    idle(25);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    check("busy_drained", {31'd0, wBusy}, 32'd0);
    do_reset();

    // same-destination conflict
    drive_cycle(1'b1, 16'h7001, {6'd5, 6'd0, 6'd0, 6'd5}, 4'b1001);
    idle(2);
    check("conf_first", {28'd0, wRegs0[23:20]}, 32'd1);
    idle(1);
    check("conf_final", {28'd0, wRegs0[23:20]}, 32'd7);
    idle(3);

    // wrap-around with upstream honouring wBusy
    sent = 0;
    for (int c = 0; c < 200 && sent < 10; c++) begin
      if (wBusy) begin
        idle(1);
      end else begin
        int l;
        logic [23:0] ds;
        l  = $urandom_range(3, 0);
        ds = 24'($urandom);
        ds[l*6 +: 6] = 6'(20 + sent);
        drive_cycle(1'b1, 16'($urandom), ds, 4'(1 << l));
        sent++;
      end
    end
    check("wrap_sent", sent, 32'd10);
    idle(30);
    check("wrap_ovf", {31'd0, overflow}, 32'd0);

    // empty enable
    n_done_seen = 0;
    drive_cycle(1'b1, 16'($urandom), 24'($urandom), 4'h0);
    idle(6);
    check("empty_done_cnt", n_done_seen, 32'd1);

    // random traffic, upstream sometimes ignoring wBusy
    for (int i = 0; i < 300; i++) begin
      drive_cycle(1'($urandom_range(1, 0)), 16'($urandom), 24'($urandom), 4'($urandom));
    end
    idle(40);

    // reset during the second WRITE cycle of a four-lane entry
    drive_cycle(1'b1, 16'h9876, {6'd43, 6'd42, 6'd41, 6'd40}, 4'hF);
    idle(2);
    check("pre_rst_write", {28'd0, wRegs5[3:0]}, 32'h6);
    do_reset();
    check("mid_rst_regs5", wRegs5, 32'd0);
    check("mid_rst_busy", {31'd0, wBusy}, 32'd0);
    n_done_seen = 0;
    idle(8);
    check("post_rst_regs5", wRegs5, 32'd0);
    check("post_rst_done", n_done_seen, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/regs_writeback.md
REGS_WRITEBACK -- requirements
Module: regs_writeback

Interface
REQ-001 The module SHALL have these parameters, one per line as name, default and meaning:
- DATA_WIDTH, 4, bits per lane value.
- LANES, 4, lanes per input word.
- REGS_INPUTS, 64, register-file entries.
- REGS_BITS_PER_INPUT, 32, bits per exported register bus.
- FIFO_DEPTH, 4, input FIFO entries (power of 2).
REQ-002 The module SHALL have these ports, one per line as name, direction, width and meaning:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word offered this cycle.
- data_in  in  DATA_WIDTH*LANES  lane i in bits [i*DATA_WIDTH +: DATA_WIDTH].
- dest  in  LANES*$clog2(REGS_INPUTS)  lane i destination index in bits [i*6 +: 6].
- lane_en  in  LANES  per-lane write enable.
- wBusy  out  1  back-pressure to the upstream selector/scheduler.
- wRegs0..wRegs7  out  REGS_BITS_PER_INPUT each  register-file contents.
- wr_done  out  1  one-cycle pulse when an entry finishes.
- overflow  out  1  sticky flag, set when an offered word is dropped.

Function
REQ-003 Register k SHALL occupy wRegs[k/8] bits [(k%8)*4 +: 4], so that wRegs0 bits [3:0] hold register 0.
REQ-004 An input entry SHALL be accepted into the FIFO at a rising edge when in_valid=1 and the FIFO is not full. The entry consists of {lane_en, dest, data_in}.
REQ-005 When in_valid=1 and the FIFO is full, the word SHALL be dropped, the FIFO SHALL be unchanged, and overflow SHALL be set to 1 and hold 1 until reset.
REQ-006 wBusy SHALL be registered and equal 1 whenever the FIFO count is at least FIFO_DEPTH-1, giving upstream one cycle of slack.
REQ-007 The FSM SHALL have two states, IDLE and WRITE. The reset state is IDLE.
REQ-008 In IDLE with the FIFO non-empty, the head entry SHALL be popped into a working register at the next edge and the state SHALL become WRITE. In IDLE with the FIFO empty, the FSM SHALL stay in IDLE.
REQ-009 In WRITE, each cycle SHALL write the lowest-indexed remaining enabled lane to its dest register and clear that lane's pending bit. Exactly one register write SHALL occur per cycle.
REQ-010 In the WRITE cycle that performs the last pending write, wr_done SHALL be 1 (registered, visible the following cycle) and the next state SHALL be IDLE.
REQ-011 An entry with lane_en=0 SHALL spend exactly one cycle in WRITE with no register change, and wr_done SHALL still pulse.
REQ-012 If two lanes of one entry target the same register, the higher-indexed lane SHALL win because it is written later.
REQ-013 A push and a pop SHALL be allowed in the same cycle, with the count unchanged. Fullness for acceptance SHALL be evaluated on the pre-edge count, so a push while full is rejected even if a pop occurs in the same cycle.
REQ-014 Write-pointer and read-pointer SHALL wrap modulo FIFO_DEPTH with no lost or duplicated entries.
REQ-015 Latency SHALL be as follows:
- Word accepted at edge N.
- Popped at edge N+1 (FIFO was empty, FSM in IDLE).
- First enabled lane visible on wRegs after edge N+2.
- Lane j's write visible after edge N+2+j, for all lanes enabled.
REQ-016 wRegs outputs SHALL come directly from register flops, with no combinational path from any input.

Reset
REQ-017 Assertion of rst=0 SHALL immediately, independent of clk, force:
- all 64 registers to 0;
- FIFO count and both pointers to 0;
- state to IDLE;
- wBusy=0, wr_done=0, overflow=0.
REQ-018 Reset asserted mid-WRITE SHALL abandon the in-flight entry and all queued entries. Register writes already performed SHALL be cleared to 0 along with everything else.
REQ-019 After rst deasserts, the first edge SHALL be able to accept input.

Verification
REQ-020 The bench SHALL cover single write, back-pressure/overflow, same-destination conflict, wrap-around, empty-enable entry and reset mid-write:
- Single write: one word with data_in=16'hDCBA, dest={6'd63,6'd9,6'd8,6'd0}, lane_en=4'hF. Required: register 0=A, 8=B, 9=C, 63=D; wRegs0[3:0]=4'hA, wRegs1[7:0]=8'hCB, wRegs7[31:28]=4'hD; wr_done one pulse; 4 WRITE cycles.
- Back-pressure: offer 6 consecutive valid words while the FSM drains. Required: wBusy rises once count reaches 3; words arriving while count=4 are dropped; overflow=1 and stays 1.
- Conflict: lanes 0 and 3 both dest=5 with values 1 and 7, lane_en=4'b1001. Required: register 5=7 after 2 WRITE cycles.
- Wrap-around: 10 single-lane words to distinct registers, upstream honouring wBusy. Required: all 10 writes land in order, overflow=0.
- Empty enable: lane_en=0. Required: no register change, wr_done pulses once.
- Reset mid-write: rst=0 during the second WRITE cycle of a 4-lane entry. Required: all wRegs=0, state IDLE, wBusy=0, and no further writes after release.
